instr_mem_loadable: RTL

Parametrised instruction memory for the bbtron core, replacing the hard-coded program store. It is a synchronous-read RAM whose program is streamed in at run time through a valid/ready load port. A small state machine (IDLE/LOAD/RUN) gates instruction fetch. Fetches beyond the loaded program return a HALT word and flag a fault, so a runaway PC stops the core cleanly.

---
 rtl/instr_mem_loadable_pkg.sv | 25 ++
 rtl/instr_mem_loadable_if.sv | 47 ++++
 rtl/instr_mem_loadable_sdp_ram.sv | 40 ++++
 rtl/instr_mem_loadable.sv | 125 ++++++++++++
 4 files changed

// File: rtl/instr_mem_loadable_pkg.sv
// Shared encodings for the loadable instruction memory: controller states and
// the HALT instruction returned for fetches past the end of the program.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [5:0] OPC_HALT = 6'b011101;
  localparam int         OPC_MSB  = 31;
  localparam int         OPC_LSB  = 26;

  // HALT is the bare opcode with every other field zero: 32'h7400_0000.
  function automatic logic [31:0] make_halt_word();
    logic [31:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = OPC_HALT;
    return w;
  endfunction

  localparam logic [31:0] HALT_WORD_DEFAULT = make_halt_word();

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Load and fetch ports of the instruction memory, plus a debug view of the
// controller state. The master side drives the load stream and fetch requests.
interface instr_mem_loadable_if
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) ();

  // Load handshake: a beat transfers on a rising clock edge where load_valid
  // and load_ready are both 1; load_data/load_last are only meaningful with
  // load_valid, and the master must not rely on load_ready to raise load_valid.
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              load_overflow;

  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_fault;

  logic              running;
  logic [ADDR_W:0]   prog_size;
  state_e            dbg_state;

  modport master (
    output load_start, load_valid, load_data, load_last,
    input  load_ready, load_done, load_overflow,
    output fetch_en, fetch_addr,
    input  fetch_data, fetch_valid, fetch_fault,
    input  running, prog_size, dbg_state
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    output load_ready, load_done, load_overflow,
    input  fetch_en, fetch_addr,
    output fetch_data, fetch_valid, fetch_fault,
    output running, prog_size, dbg_state
  );

endinterface

// File: rtl/instr_mem_loadable_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// The read register resets to zero so the fetch output starts from a known value.
module sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i[MEM_AW-1:0]] <= wdata_i;
    end
  end

  // Callers only present in-range addresses; the read holds when re_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i[MEM_AW-1:0]];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: a program is streamed in, then fetched
// with 1-cycle latency; fetches past the program return HALT and flag a fault.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 10,
  parameter int                DEPTH     = 1024,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
  input  logic                 clock,
  input  logic                 reset,
  instr_mem_loadable_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_size_q, prog_size_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              fetch_valid_q, fetch_fault_q, sel_halt_q;

  logic              wr_en;
  logic              at_end;
  logic              fetch_hit;
  logic              in_range;
  logic [DATA_W-1:0] ram_rdata;

  assign at_end = (wr_ptr_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      prog_size_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_size_q <= prog_size_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_size_d = prog_size_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;

    // load_start always wins: a beat offered with it is dropped.
    if (bus.load_start) begin
      state_d     = LOAD;
      wr_ptr_d    = '0;
      prog_size_d = '0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.load_valid) begin
            wr_en = 1'b1;
            if (bus.load_last || at_end) begin
              state_d     = RUN;
              prog_size_d = {1'b0, wr_ptr_q} + 1'b1;
              done_d      = 1'b1;
              overflow_d  = at_end && !bus.load_last;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
        IDLE, RUN: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign fetch_hit = bus.fetch_en && (state_q == RUN);
  assign in_range  = ({1'b0, bus.fetch_addr} < prog_size_q);

  // sel_halt_q only moves on a serviced fetch so fetch_data holds between fetches.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      sel_halt_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_hit;
      fetch_fault_q <= fetch_hit && !in_range;
      if (fetch_hit) begin
        sel_halt_q <= !in_range;
      end
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.load_data),
    .re_i    (fetch_hit && in_range),
    .raddr_i (bus.fetch_addr),
    .rdata_o (ram_rdata)
  );

  assign bus.load_ready    = (state_q == LOAD);
  assign bus.load_done     = done_q;
  assign bus.load_overflow = overflow_q;
  assign bus.fetch_data    = sel_halt_q ? HALT_WORD : ram_rdata;
  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.fetch_fault   = fetch_fault_q;
  assign bus.running       = (state_q == RUN);
  assign bus.prog_size     = prog_size_q;
  assign bus.dbg_state     = state_q;

endmodule
